// File: rtl/fm_affine_stage_v2.sv
// Last stage of the feature-normalisation pipeline: per-row scale/shift, then per-lane affine.
// The data and parameter streams are joined, then pass through a two-register pipeline with saturation.
module fm_affine_stage_v2 #(
    parameter int unsigned BITWIDTH = 16,
    parameter int unsigned LANES    = 8,
    parameter int unsigned FRAC     = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [1:0]                  mode,
    input  logic [BITWIDTH-1:0]         mean_variance,
    input  logic [BITWIDTH-1:0]         one_variance,
    input  logic                        stat_valid,
    output logic                        stat_ready,
    input  logic [LANES*BITWIDTH-1:0]   x,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic                        x_last,
    input  logic [LANES*BITWIDTH-1:0]   weight,
    input  logic [LANES*BITWIDTH-1:0]   bias,
    input  logic                        param_valid,
    output logic                        param_ready,
    input  logic                        param_last,
    output logic [LANES*BITWIDTH-1:0]   normal_out,
    output logic                        normal_out_valid,
    output logic [LANES*BITWIDTH-1:0]   out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        err_align,
    input  logic                        err_clear
);
    localparam int unsigned DW = LANES * BITWIDTH;
    localparam int unsigned PW = 2 * BITWIDTH;
    localparam int unsigned SW = 2 * BITWIDTH + 1;
    localparam logic [BITWIDTH-1:0] ONE = BITWIDTH'(1 << FRAC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q;
    logic [BITWIDTH-1:0]   mean_q, onev_q;
    logic                  s1_valid_q, s1_last_q, nov_q;
    logic [DW-1:0]         n_q, w_q, b_q, out_q;
    logic                  out_valid_q, out_last_q, err_q;
    logic [DW-1:0]         n_d, y_d;
    logic [BITWIDTH-1:0]   mul_e, sub_e;
    logic                  adv1, adv2, run, fire, stat_fire;

    // Clamp a wide signed value into the lane range.
    function automatic logic [BITWIDTH-1:0] sat_f(input logic [SW-1:0] v);
        if ((&v[SW-1:BITWIDTH-1]) || !(|v[SW-1:BITWIDTH-1])) return v[BITWIDTH-1:0];
        else if (v[SW-1]) return {1'b1, {(BITWIDTH-1){1'b0}}};
        else return {1'b0, {(BITWIDTH-1){1'b1}}};
    endfunction

    function automatic logic [SW-1:0] mul_shift_f(input logic [BITWIDTH-1:0] a,
                                                   input logic [BITWIDTH-1:0] b);
        logic signed [PW-1:0] p;
        p = PW'($signed(a)) * PW'($signed(b));
        p = p >>> FRAC;
        return {p[PW-1], p};
    endfunction

    function automatic logic [SW-1:0] sext_f(input logic [BITWIDTH-1:0] a);
        return {{(BITWIDTH+1){a[BITWIDTH-1]}}, a};
    endfunction

    assign adv2        = !out_valid_q || out_ready;
    assign adv1        = !s1_valid_q || adv2;
    assign run         = (state_q == RUN);
    assign fire        = run && x_valid && param_valid && adv1;
    assign stat_fire   = (state_q == IDLE) && stat_valid;
    assign stat_ready  = (state_q == IDLE);
    assign x_ready     = run && param_valid && adv1;
    assign param_ready = run && x_valid && adv1;

    // Row FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (stat_valid) state_d = RUN;
            RUN:     if (fire && (x_last || param_last)) state_d = DRAIN;
            DRAIN:   if (out_valid_q && out_ready && out_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage 1 and stage 2 lane arithmetic.
    always_comb begin
        n_d   = '0;
        y_d   = '0;
        mul_e = (mode_q == 2'd0 || mode_q == 2'd1) ? onev_q : ONE;
        sub_e = (mode_q == 2'd0) ? mean_q : '0;
        for (int i = 0; i < int'(LANES); i++) begin
            n_d[i*BITWIDTH +: BITWIDTH] =
                sat_f(mul_shift_f(x[i*BITWIDTH +: BITWIDTH], mul_e) - sext_f(sub_e));
            case (mode_q)
                2'd2:    y_d[i*BITWIDTH +: BITWIDTH] = n_q[i*BITWIDTH +: BITWIDTH];
                2'd1:    y_d[i*BITWIDTH +: BITWIDTH] =
                             sat_f(mul_shift_f(n_q[i*BITWIDTH +: BITWIDTH], w_q[i*BITWIDTH +: BITWIDTH]));
                default: y_d[i*BITWIDTH +: BITWIDTH] =
                             sat_f(mul_shift_f(n_q[i*BITWIDTH +: BITWIDTH], w_q[i*BITWIDTH +: BITWIDTH])
                                   + sext_f(b_q[i*BITWIDTH +: BITWIDTH]));
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            mean_q      <= '0;
            onev_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            nov_q       <= 1'b0;
            n_q         <= '0;
            w_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (stat_fire) begin
                mode_q <= mode;
                mean_q <= mean_variance;
                onev_q <= one_variance;
            end
            nov_q <= fire;
            if (fire) begin
                n_q        <= n_d;
                w_q        <= weight;
                b_q        <= bias;
                s1_last_q  <= x_last || param_last;
                s1_valid_q <= 1'b1;
            end else if (adv1) begin
                s1_valid_q <= 1'b0;
            end
            // Output register only moves when the consumer is not stalling it.
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                out_last_q  <= s1_valid_q && s1_last_q;
                if (s1_valid_q) out_q <= y_d;
            end
            if (err_clear) err_q <= 1'b0;
            else if (fire && (x_last != param_last)) err_q <= 1'b1;
        end
    end

    assign normal_out       = n_q;
    assign normal_out_valid = nov_q;
    assign out              = out_q;
    assign out_valid        = out_valid_q;
    assign out_last         = out_last_q;
    assign err_align        = err_q;

endmodule

// File: tb/tb_fm_affine_stage_v2.sv
// Directed bench for fm_affine_stage_v2: modes, saturation, backpressure, skew, reset.
module tb_fm_affine_stage_v2;
    localparam int unsigned BW = 16;
    localparam int unsigned LN = 8;
    localparam int unsigned DW = BW * LN;

    logic          clk = 1'b0;
    logic          rstn;
    logic [1:0]    mode;
    logic [BW-1:0] mean_variance, one_variance;
    logic          stat_valid, stat_ready;
    logic [DW-1:0] x, weight, bias;
    logic          x_valid, x_ready, x_last;
    logic          param_valid, param_ready, param_last;
    logic [DW-1:0] normal_out, out;
    logic          normal_out_valid, out_valid, out_ready, out_last;
    logic          err_align, err_clear;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fm_affine_stage_v2 #(.BITWIDTH(BW), .LANES(LN), .FRAC(8)) dut (
        .clk(clk), .rstn(rstn), .mode(mode),
        .mean_variance(mean_variance), .one_variance(one_variance),
        .stat_valid(stat_valid), .stat_ready(stat_ready),
        .x(x), .x_valid(x_valid), .x_ready(x_ready), .x_last(x_last),
        .weight(weight), .bias(bias),
        .param_valid(param_valid), .param_ready(param_ready), .param_last(param_last),
        .normal_out(normal_out), .normal_out_valid(normal_out_valid),
        .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .err_align(err_align), .err_clear(err_clear)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [BW-1:0] v);
        return {LN{v}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_stats(input logic [1:0] md, input logic [BW-1:0] mean, input logic [BW-1:0] onev);
        mode = md; mean_variance = mean; one_variance = onev; stat_valid = 1'b1;
        step();
        stat_valid = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [1:0] md,
                              input logic [BW-1:0] mean, input logic [BW-1:0] onev,
                              input logic [DW-1:0] xv, input logic [DW-1:0] wv, input logic [DW-1:0] bv,
                              input logic [DW-1:0] en, input logic [DW-1:0] ey);
        send_stats(md, mean, onev);
        x = xv; weight = wv; bias = bv;
        x_valid = 1'b1; param_valid = 1'b1; x_last = 1'b1; param_last = 1'b1;
        #1;
        check({tag, "_xrdy"}, DW'(x_ready), DW'(1));
        check({tag, "_prdy"}, DW'(param_ready), DW'(1));
        step();
        x_valid = 1'b0; param_valid = 1'b0; x_last = 1'b0; param_last = 1'b0;
        check({tag, "_n"}, normal_out, en);
        check({tag, "_nv"}, DW'(normal_out_valid), DW'(1));
        check({tag, "_ov_early"}, DW'(out_valid), DW'(0));
        step();
        check({tag, "_y"}, out, ey);
        check({tag, "_ov"}, DW'(out_valid), DW'(1));
        check({tag, "_olast"}, DW'(out_last), DW'(1));
        check({tag, "_nv_once"}, DW'(normal_out_valid), DW'(0));
        check({tag, "_busy"}, DW'(stat_ready), DW'(0));
        step();
        check({tag, "_idle"}, DW'(stat_ready), DW'(1));
        check({tag, "_ov_off"}, DW'(out_valid), DW'(0));
    endtask

    task automatic backpressure();
        logic [DW-1:0] bx [4];
        logic [DW-1:0] prev_out;
        logic [3:0]    pat;
        int idx, rcv, nv;
        bit prev_stall, done;
        bx[0] = rep(16'h0111); bx[1] = rep(16'h0222);
        bx[2] = rep(16'h0333); bx[3] = 128'h8000_7FFF_0001_FFFF_1234_ABCD_0000_0100;
        pat = 4'b1001;
        idx = 0; rcv = 0; nv = 0; prev_stall = 1'b0; done = 1'b0; prev_out = '0;
        send_stats(2'd2, 16'h0040, 16'h0080);
        weight = rep(16'h1234); bias = rep(16'h0100);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            x_valid = (idx < 4); param_valid = (idx < 4);
            x_last = (idx == 3); param_last = (idx == 3);
            if (idx < 4) x = bx[idx];
            out_ready = pat[cyc % 4];
            #1;
            if (normal_out_valid) nv++;
            if (prev_stall) check("bp_hold", out, prev_out);
            if (out_valid && out_ready && rcv < 4) begin
                check("bp_data", out, bx[rcv]);
                check("bp_last", DW'(out_last), DW'(rcv == 3));
                rcv++;
                if (rcv == 4) done = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_out = out;
            if (x_valid && x_ready) idx++;
            step();
        end
        x_valid = 1'b0; param_valid = 1'b0; x_last = 1'b0; param_last = 1'b0; out_ready = 1'b1;
        check("bp_done", DW'(done), DW'(1));
        check("bp_count", DW'(rcv), DW'(4));
        check("bp_nv_count", DW'(nv), DW'(4));
        check("bp_idle", DW'(stat_ready), DW'(1));
        check("bp_ov_off", DW'(out_valid), DW'(0));
    endtask

    task automatic skewed();
        send_stats(2'd2, 16'h0000, 16'h0100);
        x = rep(16'h0555); weight = rep(16'h0100); bias = '0;
        x_valid = 1'b1; param_valid = 1'b0; x_last = 1'b1; param_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("skew_xrdy", DW'(x_ready), DW'(0));
            step();
            check("skew_nofire", DW'(normal_out_valid), DW'(0));
        end
        param_valid = 1'b1;
        #1;
        check("skew_xrdy_join", DW'(x_ready), DW'(1));
        step();
        x_valid = 1'b0; param_valid = 1'b0; x_last = 1'b0;
        check("skew_err", DW'(err_align), DW'(1));
        check("skew_n", normal_out, rep(16'h0555));
        step();
        check("skew_y", out, rep(16'h0555));
        check("skew_olast", DW'(out_last), DW'(1));
        check("skew_drain", DW'(stat_ready), DW'(0));
        step();
        check("skew_idle", DW'(stat_ready), DW'(1));
        check("skew_err_sticky", DW'(err_align), DW'(1));
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("skew_err_clr", DW'(err_align), DW'(0));
    endtask

    task automatic reset_mid_row();
        send_stats(2'd0, 16'h0040, 16'h0080);
        out_ready = 1'b0;
        x = rep(16'h0200); weight = rep(16'h0200); bias = rep(16'h0100);
        x_valid = 1'b1; param_valid = 1'b1; x_last = 1'b0; param_last = 1'b0;
        step();
        x_last = 1'b1;
        #1;
        check("rst_fill_xrdy", DW'(x_ready), DW'(1));
        step();
        x_last = 1'b0;
        check("rst_full_ov", DW'(out_valid), DW'(1));
        check("rst_full_y", out, rep(16'h0280));
        check("rst_full_err", DW'(err_align), DW'(1));
        #3;
        rstn = 1'b0;
        #1;
        check("rst_stat_ready", DW'(stat_ready), DW'(1));
        check("rst_xrdy", DW'(x_ready), DW'(0));
        check("rst_prdy", DW'(param_ready), DW'(0));
        check("rst_out", out, '0);
        check("rst_ov", DW'(out_valid), DW'(0));
        check("rst_olast", DW'(out_last), DW'(0));
        check("rst_n", normal_out, '0);
        check("rst_nv", DW'(normal_out_valid), DW'(0));
        check("rst_err", DW'(err_align), DW'(0));
        x_valid = 1'b0; param_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        rstn = 1'b1;
        step();
        check("rst_after_ov", DW'(out_valid), DW'(0));
        run_single("post_rst", 2'd0, 16'h0040, 16'h0080, rep(16'h0200), rep(16'h0200),
                   rep(16'h0100), rep(16'h00C0), rep(16'h0280));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; mode = '0; mean_variance = '0; one_variance = '0; stat_valid = 1'b0;
        x = '0; weight = '0; bias = '0; x_valid = 1'b0; x_last = 1'b0;
        param_valid = 1'b0; param_last = 1'b0; out_ready = 1'b1; err_clear = 1'b0;
        #2;
        check("reset_stat_ready", DW'(stat_ready), DW'(1));
        check("reset_xrdy", DW'(x_ready), DW'(0));
        check("reset_prdy", DW'(param_ready), DW'(0));
        check("reset_out", out, '0);
        check("reset_ov", DW'(out_valid), DW'(0));
        check("reset_olast", DW'(out_last), DW'(0));
        check("reset_n", normal_out, '0);
        check("reset_nv", DW'(normal_out_valid), DW'(0));
        check("reset_err", DW'(err_align), DW'(0));
        step();
        step();
        rstn = 1'b1;
        step();

        run_single("m0", 2'd0, 16'h0040, 16'h0080, rep(16'h0200), rep(16'h0200), rep(16'h0100),
                   rep(16'h00C0), rep(16'h0280));
        run_single("m1", 2'd1, 16'h0040, 16'h0080, rep(16'h0200), rep(16'h0200), rep(16'h0100),
                   rep(16'h0100), rep(16'h0200));
        run_single("m2", 2'd2, 16'h0040, 16'h0080, rep(16'h0200), rep(16'h0200), rep(16'h0100),
                   rep(16'h0200), rep(16'h0200));
        run_single("m3", 2'd3, 16'h0040, 16'h0080, rep(16'h0200), rep(16'h0200), rep(16'h0100),
                   rep(16'h0200), rep(16'h0500));
        run_single("sat_pos", 2'd0, 16'h0000, 16'h7FFF, rep(16'h7FFF), rep(16'h7FFF), rep(16'h7FFF),
                   rep(16'h7FFF), rep(16'h7FFF));
        run_single("sat_neg", 2'd0, 16'h7FFF, 16'h7FFF, rep(16'h8000), rep(16'h0100), rep(16'h0000),
                   rep(16'h8000), rep(16'h8000));
        run_single("floor", 2'd3, 16'h0000, 16'h0000, rep(16'hFFFF), rep(16'h0080), rep(16'h0000),
                   rep(16'hFFFF), rep(16'hFFFF));
        run_single("m2_lanes", 2'd2, 16'h1111, 16'h2222, 128'h8000_7FFF_0001_FFFF_1234_ABCD_0000_0100,
                   rep(16'h1234), rep(16'h7FFF),
                   128'h8000_7FFF_0001_FFFF_1234_ABCD_0000_0100,
                   128'h8000_7FFF_0001_FFFF_1234_ABCD_0000_0100);

        backpressure();
        skewed();
        reset_mid_row();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
